// File: rtl/restoring_divider_8x4.sv
// Sequential radix-2 restoring divider: DW-bit unsigned dividend by VW-bit divisor,
// one quotient bit per clock, valid/ready handshake on both sides.
module restoring_divider_8x4 #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [DW-1:0] shift_reg;
    logic [VW-1:0] divisor_reg;
    logic [VW:0]   partial_rem;
    logic [CW-1:0] count;
    logic          last_iter;
    logic [VW+1:0] shifted;
    logic [VW+1:0] trial;
    logic          no_borrow;
    logic [VW:0]   next_rem;
    logic [DW-1:0] next_shift;

    // One restoring step; the extra top bit of trial is the borrow out.
    always_comb begin
        last_iter  = (count == CW'(DW - 1));
        shifted    = {partial_rem, shift_reg[DW-1]};
        trial      = shifted - {2'b00, divisor_reg};
        no_borrow  = ~trial[VW+1];
        next_rem   = no_borrow ? trial[VW:0] : shifted[VW:0];
        next_shift = {shift_reg[DW-2:0], no_borrow};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = (state == IDLE);
        out_valid  = (state == DONE);
        case (state)
            IDLE: begin
                if (in_valid) begin
                    next_state = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Result registers are separate from the shift register so they hold while the next op runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg   <= '0;
            divisor_reg <= '0;
            partial_rem <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg   <= dividend;
                        divisor_reg <= divisor;
                        partial_rem <= '0;
                        count       <= '0;
                        div_by_zero <= (divisor == '0);
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= '0;
                        end
                    end
                end
                CALC: begin
                    shift_reg   <= next_shift;
                    partial_rem <= next_rem;
                    count       <= count + CW'(1);
                    if (last_iter) begin
                        quotient  <= next_shift;
                        remainder <= next_rem[VW-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider_8x4.sv
// Scoreboard bench for restoring_divider_8x4: expected results are queued at accept
// and popped when the divider hands a result over.
module tb_restoring_divider_8x4;
    localparam int DW = 8;
    localparam int VW = 4;

    typedef struct packed {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dbz;
    } result_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    result_t sb[$];
    int checks    = 0;
    int failures  = 0;
    int accepted  = 0;
    int delivered = 0;

    restoring_divider_8x4 #(.DW(DW), .VW(VW)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .dividend(dividend),
        .divisor(divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic result_t model(input int a, input int b);
        result_t res;
        if (b == 0) begin
            res.q   = '1;
            res.r   = '0;
            res.dbz = 1'b1;
        end else begin
            res.q   = DW'(a / b);
            res.r   = VW'(a % b);
            res.dbz = 1'b0;
        end
        return res;
    endfunction

    function automatic result_t take_expected();
        if (sb.size() == 0) return '0;
        return sb.pop_front();
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int a, input int b);
        int n = 0;
        dividend = DW'(a);
        divisor  = VW'(b);
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL accept_timeout in_ready=%0b required=1", in_ready);
        end else begin
            tick();
            sb.push_back(model(a, b));
            accepted++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_output(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            tick();
            cycles++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL output_timeout out_valid=%0b required=1", out_valid);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready got=%0b required=1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid got=%0b required=0", out_valid);
        end
        checks++;
        if ({quotient, remainder, div_by_zero} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got q=%0d r=%0d dbz=%0b required all 0",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_first_op();
        int cyc;
        result_t exp;
        apply_stimulus(200, 7);
        wait_output(cyc);
        checks++;
        if (cyc != 8) begin
            failures++;
            $display("[TB] FAIL first_latency got=%0d required=8", cyc);
        end
        exp = take_expected();
        checks++;
        if (quotient !== 8'd28 || remainder !== 4'd4 || div_by_zero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL first_result got q=%0d r=%0d dbz=%0b required q=28 r=4 dbz=0",
                     quotient, remainder, div_by_zero);
        end
        checks++;
        if (exp !== {quotient, remainder, div_by_zero}) begin
            failures++;
            $display("[TB] FAIL first_scoreboard got q=%0d r=%0d required q=%0d r=%0d",
                     quotient, remainder, exp.q, exp.r);
        end
        delivered++;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL first_release got out_valid=%0b in_ready=%0b required 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_basic();
        int ops[3][2] = '{'{255, 15}, '{5, 9}, '{0, 1}};
        int cyc;
        result_t exp;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(ops[i][0], ops[i][1]);
            wait_output(cyc);
            exp = take_expected();
            checks++;
            if ({quotient, remainder, div_by_zero} !== exp) begin
                failures++;
                $display("[TB] FAIL basic_%0d_%0d got q=%0d r=%0d dbz=%0b required q=%0d r=%0d dbz=%0b",
                         ops[i][0], ops[i][1], quotient, remainder, div_by_zero,
                         exp.q, exp.r, exp.dbz);
            end
            delivered++;
            tick();
        end
    endtask

    task automatic test_div_by_zero();
        int cyc;
        result_t exp;
        apply_stimulus(100, 0);
        wait_output(cyc);
        checks++;
        if (cyc != 0) begin
            failures++;
            $display("[TB] FAIL dbz_latency got=%0d required=0", cyc);
        end
        exp = take_expected();
        checks++;
        if (quotient !== 8'd255 || remainder !== 4'd0 || div_by_zero !== 1'b1 ||
            exp !== {quotient, remainder, div_by_zero}) begin
            failures++;
            $display("[TB] FAIL dbz_result got q=%0d r=%0d dbz=%0b required q=255 r=0 dbz=1",
                     quotient, remainder, div_by_zero);
        end
        delivered++;
        tick();
        apply_stimulus(100, 3);
        wait_output(cyc);
        exp = take_expected();
        checks++;
        if (cyc != 8 || quotient !== 8'd33 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL after_dbz got lat=%0d q=%0d r=%0d dbz=%0b required lat=8 q=33 r=1 dbz=0",
                     cyc, quotient, remainder, div_by_zero);
        end
        delivered++;
        tick();
    endtask

    task automatic test_backpressure();
        int cyc;
        result_t exp;
        out_ready = 1'b0;
        apply_stimulus(50, 7);
        wait_output(cyc);
        exp = take_expected();
        for (int i = 0; i < 20; i++) begin
            in_valid = ~in_valid;
            dividend = DW'($urandom);
            divisor  = VW'($urandom);
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {quotient, remainder, div_by_zero} !== exp) begin
                failures++;
                $display("[TB] FAIL hold_cycle_%0d got v=%0b rdy=%0b q=%0d r=%0d required v=1 rdy=0 q=%0d r=%0d",
                         i, out_valid, in_ready, quotient, remainder, exp.q, exp.r);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        delivered++;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 8'd7 || remainder !== 4'd1) begin
            failures++;
            $display("[TB] FAIL hold_release got v=%0b rdy=%0b q=%0d r=%0d required v=0 rdy=1 q=7 r=1",
                     out_valid, in_ready, quotient, remainder);
        end
    endtask

    task automatic test_reset_during_calc();
        int cyc;
        result_t exp;
        out_ready = 1'b1;
        apply_stimulus(200, 7);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        accepted--;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || {quotient, remainder, div_by_zero} !== '0) begin
            failures++;
            $display("[TB] FAIL midcalc_reset got rdy=%0b v=%0b q=%0d r=%0d dbz=%0b required rdy=1 v=0 all 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL midcalc_no_output cycle=%0d got=%0b required=0", i, out_valid);
            end
        end
        apply_stimulus(77, 6);
        wait_output(cyc);
        exp = take_expected();
        checks++;
        if (cyc != 8 || quotient !== 8'd12 || remainder !== 4'd5 || div_by_zero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL post_reset_op got lat=%0d q=%0d r=%0d dbz=%0b required lat=8 q=12 r=5 dbz=0",
                     cyc, quotient, remainder, div_by_zero);
        end
        delivered++;
        tick();
    endtask

    task automatic run_one(input int a, input int b);
        int cyc;
        int stall;
        int q;
        int r;
        result_t exp;
        out_ready = 1'b0;
        apply_stimulus(a, b);
        wait_output(cyc);
        stall = $urandom_range(0, 2);
        repeat (stall) tick();
        out_ready = 1'b1;
        exp = take_expected();
        q = int'(quotient);
        r = int'(remainder);
        checks++;
        if ({quotient, remainder, div_by_zero} !== exp ||
            (b != 0 && (q * b + r != a || r >= b))) begin
            failures++;
            $display("[TB] FAIL sweep_%0d_%0d got q=%0d r=%0d dbz=%0b required q=%0d r=%0d dbz=%0b",
                     a, b, quotient, remainder, div_by_zero, exp.q, exp.r, exp.dbz);
        end
        delivered++;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sweep_once_%0d_%0d out_valid got=%0b required=0", a, b, out_valid);
        end
    endtask

    task automatic test_sweep();
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_one(a, b);
            end
        end
        for (int i = 0; i < 200; i++) begin
            run_one(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
        end
        checks++;
        if (sb.size() != 0 || delivered != accepted) begin
            failures++;
            $display("[TB] FAIL delivery_count got delivered=%0d pending=%0d required delivered=%0d pending=0",
                     delivered, sb.size(), accepted);
        end
    endtask

    initial begin
        test_reset();
        test_first_op();
        test_basic();
        test_div_by_zero();
        test_backpressure();
        test_reset_during_calc();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
